// File: rtl/nv_ram_rwsp_param.sv
// Parameterised register-file RAM: one write port, one read port with a captured read
// address, optional output register (OREG) and optional write-to-read forwarding (BYPASS).
module nv_ram_rwsp_param #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int OREG   = 1,
    parameter int BYPASS = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ra_q, ra_d;
    logic             s1_q, s1_d;
    logic             wr_ok;
    logic             fwd_hit;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] sel;
    logic             unused_pd;

    assign unused_pd = ^pwrbus_ram_pd;

    // Out-of-range addresses never touch the array; they read as zero.
    always_comb begin
        wr_ok   = we && ({1'b0, wa} < DEPTH_C);
        fwd_hit = (BYPASS != 0) && wr_ok && (wa == ra_q);
        rd      = '0;
        if ({1'b0, ra_q} < DEPTH_C) begin
            rd = mem_q[ra_q[IW-1:0]];
        end
        sel  = fwd_hit ? di : rd;
        ra_d = re ? ra : ra_q;
        s1_d = s1_q | re;
        if (!rstn) begin
            ra_d = '0;
            s1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        ra_q <= ra_d;
        s1_q <= s1_d;
    end

    // Array is not reset and keeps accepting writes while rstn is low.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wa[IW-1:0]] <= di;
        end
    end

    if (OREG != 0) begin : g_oreg
        logic [WIDTH-1:0] dout_q, dout_d;
        logic             dout_vld_q, dout_vld_d;

        always_comb begin
            dout_d     = dout_q;
            dout_vld_d = dout_vld_q;
            if (ore) begin
                dout_d     = sel;
                dout_vld_d = s1_q;
            end
            if (!rstn) begin
                dout_d     = '0;
                dout_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end

        assign dout     = dout_q;
        assign dout_vld = dout_vld_q;
    end else begin : g_comb
        logic unused_ore;
        assign unused_ore = ore;
        assign dout       = sel;
        assign dout_vld   = s1_q;
    end

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Bench for nv_ram_rwsp_param: three configurations share one stimulus stream; a reference
// model pushes expected outputs into a queue that an independent monitor pops and compares.
module tb_nv_ram_rwsp_param;

    typedef struct packed {
        logic [2:0]       v;
        logic [2:0][31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        re = 1'b0;
    logic        ore = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  ra = '0;
    logic [3:0]  wa = '0;
    logic [31:0] di = '0;
    logic [31:0] pd = '0;

    logic [13:0] dout0, dout1;
    logic [31:0] dout2;
    logic        vld0, vld1, vld2;

    int n_tests = 0;
    int n_fail  = 0;

    // Configurations: width, depth, address width, output register, bypass.
    int CW[3] = '{14, 14, 32};
    int CD[3] = '{8, 6, 16};
    int CA[3] = '{3, 3, 4};
    int CO[3] = '{1, 1, 0};
    int CB[3] = '{0, 1, 0};

    logic [31:0] mm [3][16];
    int          rad [3];
    bit          s1m [3];
    logic [31:0] drm [3];
    bit          vrm [3];
    exp_t        expq [$];

    nv_ram_rwsp_param #(.WIDTH(14), .DEPTH(8), .AW(3), .OREG(1), .BYPASS(0)) dut0 (
        .clk(clk), .rstn(rstn), .ra(ra[2:0]), .re(re), .ore(ore), .dout(dout0),
        .dout_vld(vld0), .wa(wa[2:0]), .we(we), .di(di[13:0]), .pwrbus_ram_pd(pd));

    nv_ram_rwsp_param #(.WIDTH(14), .DEPTH(6), .AW(3), .OREG(1), .BYPASS(1)) dut1 (
        .clk(clk), .rstn(rstn), .ra(ra[2:0]), .re(re), .ore(ore), .dout(dout1),
        .dout_vld(vld1), .wa(wa[2:0]), .we(we), .di(di[13:0]), .pwrbus_ram_pd(pd));

    nv_ram_rwsp_param #(.WIDTH(32), .DEPTH(16), .AW(4), .OREG(0), .BYPASS(0)) dut2 (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout2),
        .dout_vld(vld2), .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pd));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] wmask(input int k);
        return (CW[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << CW[k]) - 32'd1);
    endfunction

    // Data the read path presents: forwarded write data or stored word (zero out of range).
    function automatic logic [31:0] model_sel(input int k, input bit w, input int wk,
                                              input logic [31:0] dk);
        if (CB[k] != 0 && w && wk == rad[k] && wk < CD[k]) return dk;
        if (rad[k] < CD[k]) return mm[k][rad[k]];
        return 32'd0;
    endfunction

    task automatic model_step(input bit rn, input bit r, input logic [3:0] ra_v, input bit o,
                              input bit w, input logic [3:0] wa_v, input logic [31:0] d);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            int          am;
            int          rk;
            int          wk;
            logic [31:0] dk;
            logic [31:0] sv;
            bit          old_s1;
            am     = (1 << CA[k]) - 1;
            rk     = int'(ra_v) & am;
            wk     = int'(wa_v) & am;
            dk     = d & wmask(k);
            sv     = model_sel(k, w, wk, dk);
            old_s1 = s1m[k];
            if (!rn) begin
                rad[k] = 0;
                s1m[k] = 1'b0;
                drm[k] = '0;
                vrm[k] = 1'b0;
            end else begin
                if (r) begin
                    rad[k] = rk;
                    s1m[k] = 1'b1;
                end
                if (CO[k] != 0 && o) begin
                    drm[k] = sv;
                    vrm[k] = old_s1;
                end
            end
            if (w && wk < CD[k]) mm[k][wk] = dk;
            if (CO[k] != 0) begin
                e.d[k] = drm[k];
                e.v[k] = vrm[k];
            end else begin
                e.d[k] = model_sel(k, w, wk, dk);
                e.v[k] = s1m[k];
            end
        end
        expq.push_back(e);
    endtask

    task automatic cyc(input bit rn, input bit r, input logic [3:0] ra_v, input bit o,
                       input bit w, input logic [3:0] wa_v, input logic [31:0] d);
        @(negedge clk);
        rstn = rn;
        re   = r;
        ra   = ra_v;
        ore  = o;
        we   = w;
        wa   = wa_v;
        di   = d;
        pd   = $urandom;
        model_step(rn, r, ra_v, o, w, wa_v, d);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] ad [3];
        logic        av [3];
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e     = expq.pop_front();
                ad[0] = 32'(dout0);
                ad[1] = 32'(dout1);
                ad[2] = dout2;
                av[0] = vld0;
                av[1] = vld1;
                av[2] = vld2;
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("dut%0d_vld", k), 32'(av[k]), 32'(e.v[k]));
                    if (CO[k] != 0 || e.v[k]) begin
                        chk($sformatf("dut%0d_dout", k), ad[k], e.d[k]);
                    end
                end
            end
        end
    end

    initial begin : stim
        for (int a = 0; a < 16; a++) begin
            cyc(0, 0, 4'd0, 0, 1, 4'(a), 32'h5A5A_0000 | (32'(a) * 32'h111));
        end
        #2;
        chk("reset_vld0", 32'(vld0), 32'd0);
        chk("reset_dout0", 32'(dout0), 32'd0);

        cyc(1, 0, 4'd0, 0, 1, 4'd5, 32'h0000_1ABC);
        cyc(1, 1, 4'd5, 0, 0, 4'd0, 32'd0);
        #2;
        chk("comb_dout2_lat1", dout2, 32'h0000_1ABC);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 32'd0);
        #2;
        chk("default_dout0", 32'(dout0), 32'h1ABC);
        chk("default_vld0", 32'(vld0), 32'd1);

        cyc(1, 0, 4'd2, 0, 0, 4'd0, 32'd0);
        cyc(1, 0, 4'd6, 0, 0, 4'd0, 32'd0);
        cyc(1, 0, 4'd1, 1, 0, 4'd0, 32'd0);
        #2;
        chk("hold_dout0", 32'(dout0), 32'h1ABC);

        cyc(1, 0, 4'd0, 0, 1, 4'd15, 32'hDEAD_BEEF);
        cyc(1, 1, 4'd15, 0, 0, 4'd0, 32'd0);
        #2;
        chk("wide_dout2", dout2, 32'hDEAD_BEEF);

        cyc(1, 0, 4'd0, 0, 1, 4'd3, 32'h0000_0001);
        cyc(1, 1, 4'd3, 0, 0, 4'd0, 32'd0);
        cyc(1, 0, 4'd3, 1, 1, 4'd3, 32'h0000_2222);
        #2;
        chk("collide_nobyp_old", 32'(dout0), 32'h0001);
        chk("collide_byp_new", 32'(dout1), 32'h2222);
        cyc(1, 0, 4'd3, 1, 0, 4'd0, 32'd0);
        #2;
        chk("collide_nobyp_next", 32'(dout0), 32'h2222);

        cyc(1, 0, 4'd0, 0, 1, 4'd7, 32'h0000_3FFF);
        cyc(1, 1, 4'd7, 0, 0, 4'd0, 32'd0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 32'd0);
        #2;
        chk("oor_read_zero", 32'(dout1), 32'd0);
        cyc(1, 1, 4'd5, 0, 0, 4'd0, 32'd0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 32'd0);
        #2;
        chk("oor_write_ignored", 32'(dout1), 32'h1ABC);

        cyc(1, 1, 4'd3, 0, 0, 4'd0, 32'd0);
        cyc(0, 0, 4'd3, 1, 0, 4'd0, 32'd0);
        #2;
        chk("rst_mid_dout0", 32'(dout0), 32'd0);
        chk("rst_mid_vld0", 32'(vld0), 32'd0);
        chk("rst_mid_vld2", 32'(vld2), 32'd0);
        cyc(1, 1, 4'd3, 0, 0, 4'd0, 32'd0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 32'd0);
        #2;
        chk("after_rst_dout0", 32'(dout0), 32'h2222);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 40) != 0, 1'($urandom), 4'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom), $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsp_param.md
NV_RAM_RWSP_PARAM -- requirements
Module: nv_ram_rwsp_param

Interface
REQ-001 SHALL have parameter WIDTH, default 14, data bit width (1..256).
REQ-002 SHALL have parameter DEPTH, default 8, number of words (2..4096, need not be a power of two).
REQ-003 SHALL have parameter AW, default 3, address width; AW SHALL be greater than or equal to ceil(log2(DEPTH)).
REQ-004 SHALL have parameter OREG, default 1: 1 = registered output gated by ore; 0 = output taken directly from array, ore ignored.
REQ-005 SHALL have parameter BYPASS, default 0: 1 = write-to-read forwarding on address match; 0 = no forwarding.
REQ-006 SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-007 SHALL have port rstn, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port ra, input, AW, read address.
REQ-009 SHALL have port re, input, 1, read-address capture enable.
REQ-010 SHALL have port ore, input, 1, output-register load enable.
REQ-011 SHALL have port dout, output, WIDTH, read data.
REQ-012 SHALL have port dout_vld, output, 1, dout holds data from a real read.
REQ-013 SHALL have port wa, input, AW, write address.
REQ-014 SHALL have port we, input, 1, write enable.
REQ-015 SHALL have port di, input, WIDTH, write data.
REQ-016 SHALL have port pwrbus_ram_pd, input, 32, power-down control; it SHALL be accepted and SHALL have no functional effect.

Function
REQ-017 SHALL write di to M[wa] at the clock edge when we=1 and wa<DEPTH.
REQ-018 SHALL ignore any write with wa>=DEPTH; memory contents SHALL stay unchanged.
REQ-019 SHALL capture ra into ra_d at the edge when re=1; ra_d SHALL hold its value while re=0.
REQ-020 SHALL set flag s1 at the first edge with re=1 after reset; s1 SHALL stay set until reset.
REQ-021 SHALL define array read data rd = M[ra_d] when ra_d<DEPTH, and rd = all-zero when ra_d>=DEPTH.
REQ-022 SHALL, with BYPASS=1 and in the same cycle we=1 and wa==ra_d and wa<DEPTH, use di in place of rd as the selected data; otherwise the selected data SHALL be rd.
REQ-023 SHALL, with OREG=1, load the selected data into dout_r at the edge when ore=1, and drive dout=dout_r; latency from re to first possible dout update is 2 edges.
REQ-024 SHALL, with OREG=1, set dout_vld at an edge with ore=1 to the current value of s1, and hold dout_vld while ore=0.
REQ-025 SHALL, with OREG=0, drive dout combinationally from the selected data and drive dout_vld=s1; latency is 1 edge.
REQ-026 SHALL, with BYPASS=0 and a same-address write in the ore cycle, capture the old word; the new word SHALL be visible from the following cycle.
REQ-027 SHALL resolve re and we in the same cycle to different addresses independently, with no stall.
REQ-028 SHALL, when re=1 with ra==wa and we=1 in the same cycle, capture the address only; data selection then follows REQ-022 and REQ-026 in the next cycle.

Reset
REQ-029 SHALL clear ra_d, s1, dout_r and dout_vld to zero at any edge where rstn=0; dout SHALL read 0 and dout_vld SHALL read 0 from the following cycle.
REQ-030 SHALL give rstn=0 priority over re and ore in the same cycle; a read in flight during reset SHALL be discarded.
REQ-031 SHALL leave array contents unaffected by reset, and SHALL still perform writes while rstn=0.

Verification
REQ-032 Defaults: write 0x1ABC to addr 5, then re with ra=5, then ore -> dout=0x1ABC and dout_vld=1 exactly 2 edges after the re edge.
REQ-033 Hold: after REQ-032, re=0 while ra toggles, then ore pulse -> dout stays 0x1ABC.
REQ-034 Collision, same address 3 (old word 0x0001), ore cycle with we=1, di=0x2222: BYPASS=0 -> dout=0x0001 then next ore -> 0x2222; BYPASS=1 -> dout=0x2222 immediately.
REQ-035 DEPTH=6, AW=3: write 0x3FFF to addr 7 -> no array change; read addr 7 -> dout=0; read addr 5 -> earlier value intact.
REQ-036 Reset mid-read: re at cycle N, rstn=0 at cycle N+1 together with ore=1 -> dout=0 and dout_vld=0; array words still readable after reset.
REQ-037 OREG=0, WIDTH=32, DEPTH=16: write 0xDEADBEEF to addr 15, re with ra=15 -> dout=0xDEADBEEF one edge later, with ore held at 0.
